fb_access_ctrl: RTL



---
 rtl/fb_pkg.sv | 20 ++
 rtl/fb_access_ctrl_if.sv | 48 ++++
 rtl/fb_wr_fifo.sv | 41 ++++
 rtl/fb_access_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, draw-entry type and FSM states for fb_access_ctrl
package fb_pkg;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int XW        = 10;
   localparam int YW        = 9;
   localparam int CW        = 8;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] color;
   } draw_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_CLEAR
   } fb_state_e;
endpackage

// File: rtl/fb_access_ctrl_if.sv
// rtl/fb_access_ctrl_if.sv - scan, draw, clear and framebuffer signals of fb_access_ctrl
// FBCTRL_STALL_CNT_EN adds the stall_cnt observation output.
interface fb_access_ctrl_if;
   import fb_pkg::*;

   logic          scan_req;
   logic [XW-1:0] scan_x;
   logic [YW-1:0] scan_y;
   logic [CW-1:0] scan_pixel;
   logic          scan_pixel_vld;
   logic          draw_valid;
   logic          draw_ready;
   logic [XW-1:0] draw_x;
   logic [YW-1:0] draw_y;
   logic [CW-1:0] draw_color;
   logic          clear_start;
   logic [CW-1:0] clear_color;
   logic          busy;
   logic          clear_done;
   logic          fb_we;
   logic [XW-1:0] fb_px;
   logic [YW-1:0] fb_py;
   logic [CW-1:0] fb_color;
   logic [CW-1:0] fb_pixel;
`ifdef FBCTRL_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   modport slave (
      input  scan_req, scan_x, scan_y, draw_valid, draw_x, draw_y, draw_color,
      input  clear_start, clear_color, fb_pixel,
      output scan_pixel, scan_pixel_vld, draw_ready, busy, clear_done,
      output fb_we, fb_px, fb_py, fb_color
`ifdef FBCTRL_STALL_CNT_EN
      , output stall_cnt
`endif
   );

   modport master (
      output scan_req, scan_x, scan_y, draw_valid, draw_x, draw_y, draw_color,
      output clear_start, clear_color, fb_pixel,
      input  scan_pixel, scan_pixel_vld, draw_ready, busy, clear_done,
      input  fb_we, fb_px, fb_py, fb_color
`ifdef FBCTRL_STALL_CNT_EN
      , input stall_cnt
`endif
   );
endinterface

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous FIFO of draw entries with full/empty flags
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  draw_entry_t push_data_i,
   input  logic        pop_i,
   output draw_entry_t head_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);

   draw_entry_t   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/fb_access_ctrl.sv
// rtl/fb_access_ctrl.sv - framebuffer port arbiter: scan-out reads, buffered draws, full-screen clear
// FBCTRL_STALL_CNT_EN adds a saturating count of write slots lost to scan-out.
module fb_access_ctrl
   import fb_pkg::*;
#(
   parameter int H_RES      = H_RES_DEF,
   parameter int V_RES      = V_RES_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   fb_access_ctrl_if.slave   bus
);
   fb_state_e     state_q, state_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   logic [CW-1:0] clr_color_q, clr_color_d;
   logic [CW-1:0] scan_pixel_q;
   logic          scan_vld_q;
   logic          done_q, done_d;

   draw_entry_t   push_data, head;
   logic          fifo_full, fifo_empty, push, pop;
   logic          in_range, draw_ready;
   logic          clear_pend, fifo_pend, clear_wr;
   logic          fb_we;
   logic [XW-1:0] fb_px;
   logic [YW-1:0] fb_py;
   logic [CW-1:0] fb_color;

   // Off-screen draws are acknowledged but never stored.
   assign in_range   = (bus.draw_x < XW'(H_RES)) && (bus.draw_y < YW'(V_RES));
   assign draw_ready = !fifo_full && (state_q == ST_IDLE);
   assign push       = bus.draw_valid && draw_ready && in_range;
   assign push_data  = '{x: bus.draw_x, y: bus.draw_y, color: bus.draw_color};

   assign clear_pend = (state_q == ST_CLEAR);
   assign fifo_pend  = (state_q != ST_CLEAR) && !fifo_empty;
   assign clear_wr   = clear_pend && !bus.scan_req;
   assign pop        = fifo_pend && !bus.scan_req;

   fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      clr_color_d = clr_color_q;
      done_d      = 1'b0;
      fb_we       = 1'b0;
      fb_px       = '0;
      fb_py       = '0;
      fb_color    = '0;

      if (bus.scan_req) begin
         fb_px = bus.scan_x;
         fb_py = bus.scan_y;
      end else if (clear_wr) begin
         fb_we    = 1'b1;
         fb_px    = cx_q;
         fb_py    = cy_q;
         fb_color = clr_color_q;
      end else if (pop) begin
         fb_we    = 1'b1;
         fb_px    = head.x;
         fb_py    = head.y;
         fb_color = head.color;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.clear_start) begin
               clr_color_d = bus.clear_color;
               cx_d        = '0;
               cy_d        = '0;
               state_d     = fifo_empty ? ST_CLEAR : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               cx_d    = '0;
               cy_d    = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (clear_wr) begin
               if (cx_q == XW'(H_RES - 1)) begin
                  cx_d = '0;
                  if (cy_q == YW'(V_RES - 1)) begin
                     cy_d    = '0;
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     cy_d = cy_q + YW'(1);
                  end
               end else begin
                  cx_d = cx_q + XW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cx_q         <= '0;
         cy_q         <= '0;
         clr_color_q  <= '0;
         scan_pixel_q <= '0;
         scan_vld_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         clr_color_q <= clr_color_d;
         done_q      <= done_d;
         scan_vld_q  <= bus.scan_req;
         if (bus.scan_req) scan_pixel_q <= bus.fb_pixel;
      end
   end

`ifdef FBCTRL_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (bus.scan_req && (clear_pend || fifo_pend) && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_q;
`endif

   assign bus.scan_pixel     = scan_pixel_q;
   assign bus.scan_pixel_vld = scan_vld_q;
   assign bus.draw_ready     = draw_ready;
   assign bus.busy           = (state_q != ST_IDLE);
   assign bus.clear_done     = done_q;
   assign bus.fb_we          = fb_we;
   assign bus.fb_px          = fb_px;
   assign bus.fb_py          = fb_py;
   assign bus.fb_color       = fb_color;
endmodule
